// File: rtl/audio_clk_gen.sv
// Fractional-N NCO deriving BCLK, LRCLK/frame sync, slot/bit position and lock for a codec port.
// Latency: accumulator carry to bclk edge, strobes, position and lrclk update is one refclk cycle.
// Backpressure: none; free-running clock generator, en=0 or reset returns everything to idle.
module audio_clk_gen #(
  parameter int ACC_W       = 32,
  parameter int NUM_SLOTS   = 2,
  parameter int SLOT_W      = 32,
  parameter int LOCK_FRAMES = 4,
  localparam int SLOT_IW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int BIT_IW     = (SLOT_W > 1) ? $clog2(SLOT_W) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic               mode,
  output logic               bclk,
  output logic               lrclk,
  output logic               bclk_rise,
  output logic               bclk_fall,
  output logic [SLOT_IW-1:0] slot,
  output logic [BIT_IW-1:0]  bit_idx,
  output logic               frame_start,
  output logic               locked
);

  localparam int CNT_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [SLOT_IW-1:0] SLOT_LAST = SLOT_IW'(NUM_SLOTS - 1);
  localparam logic [SLOT_IW-1:0] SLOT_HALF = SLOT_IW'(NUM_SLOTS / 2);
  localparam logic [BIT_IW-1:0]  BIT_LAST  = BIT_IW'(SLOT_W - 1);
  localparam logic [CNT_W-1:0]   LOCK_N    = CNT_W'(LOCK_FRAMES);

  // Registered state
  logic [ACC_W-1:0]   acc_q,         acc_d;
  logic [ACC_W-1:0]   fw_act_q,      fw_act_d;
  logic               mode_q,        mode_d;
  logic               bclk_q,        bclk_d;
  logic               lrclk_q,       lrclk_d;
  logic               bclk_rise_q,   bclk_rise_d;
  logic               bclk_fall_q,   bclk_fall_d;
  logic [SLOT_IW-1:0] slot_q,        slot_d;
  logic [BIT_IW-1:0]  bit_idx_q,     bit_idx_d;
  logic               frame_start_q, frame_start_d;
  logic [CNT_W-1:0]   lock_cnt_q,    lock_cnt_d;
  logic               locked_q,      locked_d;

  // Combinational helpers
  logic [ACC_W:0]     sum;
  logic               tick;
  logic [SLOT_IW-1:0] slot_after;

  // Phase accumulator: the carry out of acc+fw_act is the half-period tick.
  // Words at or above half scale saturate at one tick per cycle, so BCLK
  // tops out at refclk/2 instead of aliasing back down.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, fw_act_q};
    tick  = sum[ACC_W] | fw_act_q[ACC_W-1];
    acc_d = '0;
    if (en) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  // BCLK toggles on every tick; the edge strobes are registered with it.
  always_comb begin
    bclk_d      = bclk_q;
    bclk_rise_d = 1'b0;
    bclk_fall_d = 1'b0;
    if (!en) begin
      bclk_d = 1'b0;
    end else if (tick) begin
      bclk_d      = ~bclk_q;
      bclk_rise_d = ~bclk_q;
      bclk_fall_d = bclk_q;
    end
  end

  // Bit/slot position advances on each falling BCLK edge. Idle parks at the
  // last bit of the last slot so the first fall after enable starts a frame.
  always_comb begin
    slot_d        = slot_q;
    bit_idx_d     = bit_idx_q;
    frame_start_d = 1'b0;
    if (!en) begin
      slot_d    = SLOT_LAST;
      bit_idx_d = BIT_LAST;
    end else if (bclk_fall_d) begin
      if (bit_idx_q == BIT_LAST) begin
        bit_idx_d = '0;
        if (slot_q == SLOT_LAST) begin
          slot_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          slot_d = slot_q + SLOT_IW'(1);
        end
      end else begin
        bit_idx_d = bit_idx_q + BIT_IW'(1);
      end
    end
  end

  // Word select: I2S switches one BCLK ahead of the slot boundary to the half
  // owning the upcoming slot; DSP raises a one-BCLK pulse just before slot 0.
  always_comb begin
    lrclk_d    = lrclk_q;
    slot_after = (slot_d == SLOT_LAST) ? '0 : slot_d + SLOT_IW'(1);
    if (!en) begin
      lrclk_d = 1'b0;
    end else if (bclk_fall_d) begin
      if (mode_q) begin
        lrclk_d = (slot_d == SLOT_LAST) && (bit_idx_d == BIT_LAST);
      end else if (bit_idx_d == BIT_LAST) begin
        lrclk_d = (slot_after >= SLOT_HALF);
      end
    end
  end

  // Configuration capture and lock tracking. A new word is only adopted on a
  // frame boundary, so the accumulator keeps its phase and BCLK never runts.
  // Any mismatch between the requested and active word drops lock at once.
  always_comb begin
    fw_act_d   = fw_act_q;
    mode_d     = mode_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!en) begin
      fw_act_d   = freq_word;
      mode_d     = mode;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      if (frame_start_d) begin
        fw_act_d = freq_word;
      end
      if (freq_word != fw_act_q) begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end else if (frame_start_q) begin
        if (lock_cnt_q != LOCK_N) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
        if (lock_cnt_d == LOCK_N) begin
          locked_d = 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low reset to the idle state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      fw_act_q      <= freq_word;
      mode_q        <= mode;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      slot_q        <= SLOT_LAST;
      bit_idx_q     <= BIT_LAST;
      frame_start_q <= 1'b0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      fw_act_q      <= fw_act_d;
      mode_q        <= mode_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      bclk_rise_q   <= bclk_rise_d;
      bclk_fall_q   <= bclk_fall_d;
      slot_q        <= slot_d;
      bit_idx_q     <= bit_idx_d;
      frame_start_q <= frame_start_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = bclk_rise_q;
  assign bclk_fall   = bclk_fall_q;
  assign slot        = slot_q;
  assign bit_idx     = bit_idx_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

  // Strobe sanity: edges are exclusive and consistent with the bclk level.
  a_edge_excl : assert property (@(posedge refclk) disable iff (!rst_n)
    !(bclk_rise_q && bclk_fall_q));
  a_rise_lvl : assert property (@(posedge refclk) disable iff (!rst_n)
    bclk_rise_q |-> bclk_q);
  a_fs_on_fall : assert property (@(posedge refclk) disable iff (!rst_n)
    frame_start_q |-> bclk_fall_q);

endmodule

// File: tb/tb_audio_clk_gen.sv
// Bench for audio_clk_gen: I2S cadence/lock/reconfig, fractional rate, idle on reset/disable, DSP pulse.
// Latency: expected event times are pushed to queues and popped as the DUT strobes appear.
// Backpressure: not applicable; stimulus drives en/freq_word/mode on the falling edge.
module tb_audio_clk_gen;

  localparam int FRAME_A = 64;   // 2 slots x 32 bits
  localparam int FRAME_B = 128;  // 8 slots x 16 bits

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, mode_a, en_b, mode_b;
  logic [31:0] fw_a, fw_b;

  logic        bclk_a, lrclk_a, rise_a, fall_a, fs_a, locked_a;
  logic [0:0]  slot_a;
  logic [4:0]  bit_a;
  logic        bclk_b, lrclk_b, rise_b, fall_b, fs_b, locked_b;
  logic [2:0]  slot_b;
  logic [3:0]  bit_b;

  audio_clk_gen u_dut_a (
    .refclk(clk), .rst_n(rst_n), .en(en_a), .freq_word(fw_a), .mode(mode_a),
    .bclk(bclk_a), .lrclk(lrclk_a), .bclk_rise(rise_a), .bclk_fall(fall_a),
    .slot(slot_a), .bit_idx(bit_a), .frame_start(fs_a), .locked(locked_a)
  );

  audio_clk_gen #(.NUM_SLOTS(8), .SLOT_W(16)) u_dut_b (
    .refclk(clk), .rst_n(rst_n), .en(en_b), .freq_word(fw_b), .mode(mode_b),
    .bclk(bclk_b), .lrclk(lrclk_b), .bclk_rise(rise_b), .bclk_fall(fall_b),
    .slot(slot_b), .bit_idx(bit_b), .frame_start(fs_b), .locked(locked_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enabled-edge counters: value k at a falling edge means k enabled edges so far.
  int t_a = 0;
  int t_b = 0;
  always @(posedge clk) begin
    if (rst_n && en_a) t_a <= t_a + 1; else t_a <= 0;
    if (rst_n && en_b) t_b <= t_b + 1; else t_b <= 0;
  end

  // Scoreboard queues of expected event times
  int q_rise[$], q_fall[$], q_fs[$], q_lr[$], q_lock[$];
  int q_fs_b[$], q_lr_b[$];

  bit   mon_a_on = 1'b1;
  logic lr_prev_a = 1'b0, lock_prev_a = 1'b0, lr_prev_b = 1'b0;
  int   n_rise = 0, n_fall = 0, n_fs = 0;
  int   hi_b = 0, pulses_b = 0;

  // Monitor A: pop and compare every observed event while enabled
  always @(negedge clk) begin
    if (mon_a_on && t_a > 0) begin
      if (rise_a) begin
        if (q_rise.size() > 0) check_eq("bclk_rise_t", t_a, q_rise.pop_front());
        else check_eq("bclk_rise_extra", t_a, -1);
      end
      if (fall_a) begin
        if (q_fall.size() > 0) check_eq("bclk_fall_t", t_a, q_fall.pop_front());
        else check_eq("bclk_fall_extra", t_a, -1);
      end
      if (fs_a) begin
        if (q_fs.size() > 0) check_eq("frame_start_t", t_a, q_fs.pop_front());
        else check_eq("frame_start_extra", t_a, -1);
        check_eq("fs_slot", slot_a, 0);
        check_eq("fs_bit", bit_a, 0);
      end
      if (lrclk_a != lr_prev_a) begin
        if (q_lr.size() > 0) check_eq("lrclk_edge_t", t_a, q_lr.pop_front());
        else check_eq("lrclk_edge_extra", t_a, -1);
      end
      if (locked_a != lock_prev_a) begin
        if (q_lock.size() > 0) check_eq("locked_edge_t", t_a, q_lock.pop_front());
        else check_eq("locked_edge_extra", t_a, -1);
      end
    end
    if (!mon_a_on && t_a > 0) begin
      if (rise_a) n_rise++;
      if (fall_a) n_fall++;
      if (fs_a)   n_fs++;
    end
    lr_prev_a   = lrclk_a;
    lock_prev_a = locked_a;
  end

  // Monitor B: DSP frame sync timing and pulse width
  always @(negedge clk) begin
    if (t_b > 0) begin
      if (fs_b) begin
        if (q_fs_b.size() > 0) check_eq("dsp_fs_t", t_b, q_fs_b.pop_front());
        else check_eq("dsp_fs_extra", t_b, -1);
      end
      if (lrclk_b) hi_b++;
      if (lrclk_b != lr_prev_b) begin
        if (q_lr_b.size() > 0) check_eq("dsp_lr_edge_t", t_b, q_lr_b.pop_front());
        else check_eq("dsp_lr_edge_extra", t_b, -1);
        if (!lrclk_b) begin
          check_eq("dsp_width", hi_b, 2);
          check_eq("dsp_end_on_fs", fs_b, 1);
          pulses_b++;
        end
      end
      if (!lrclk_b) hi_b = 0;
    end
    lr_prev_b = lrclk_b;
  end

  // Expected events for a stretch starting at t0 with acc=0, bclk=0, ticking
  // every 'per' edges; p0 is the frame position of the first falling edge.
  task automatic push_regime(input int t0, input int per, input int p0, input int t_end);
    for (int i = 1; t0 + per * i <= t_end; i++) begin
      int t;
      int p;
      t = t0 + per * i;
      if (i % 2 == 1) begin
        q_rise.push_back(t);
      end else begin
        p = p0 + i / 2 - 1;
        q_fall.push_back(t);
        if (p % FRAME_A == 0) q_fs.push_back(t);
        if (p % FRAME_A == 31 || p % FRAME_A == 63) q_lr.push_back(t);
      end
    end
  endtask

  task automatic run_to_a(input int target);
    for (int i = 0; i < target + 20 && t_a < target; i++) @(negedge clk);
    #1;
    if (t_a != target) check_eq("run_to_a_timeout", t_a, target);
  endtask

  task automatic run_to_b(input int target);
    for (int i = 0; i < target + 20 && t_b < target; i++) @(negedge clk);
    #1;
    if (t_b != target) check_eq("run_to_b_timeout", t_b, target);
  endtask

  task automatic check_drained();
    check_eq("rise_left", q_rise.size(), 0);
    check_eq("fall_left", q_fall.size(), 0);
    check_eq("fs_left", q_fs.size(), 0);
    check_eq("lr_left", q_lr.size(), 0);
    check_eq("lock_left", q_lock.size(), 0);
  endtask

  task automatic check_idle_a();
    check_eq("idle_bclk", bclk_a, 0);
    check_eq("idle_lrclk", lrclk_a, 0);
    check_eq("idle_slot", slot_a, 1);
    check_eq("idle_bit", bit_a, 31);
    check_eq("idle_locked", locked_a, 0);
    check_eq("idle_rise", rise_a, 0);
    check_eq("idle_fall", fall_a, 0);
    check_eq("idle_fs", fs_a, 0);
  endtask

  initial begin
    longint unsigned ticks;
    longint          exp_rise, exp_fall, exp_fs;

    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    mode_a = 1'b0;
    mode_b = 1'b1;
    fw_a   = 32'h4000_0000;
    fw_b   = 32'h8000_0000;
    repeat (3) @(negedge clk);
    check_idle_a();
    rst_n = 1'b1;
    @(negedge clk);

    // I2S cadence at 2^30, lock, then switch to 2^29 at edge 1700. The switch
    // lands on the frame_start at 2056; lock re-counts frames from there.
    push_regime(0, 4, 0, 2056);
    push_regime(2056, 8, 1, 6210);
    q_lock.push_back(1545);
    q_lock.push_back(1701);
    q_lock.push_back(5129);
    en_a = 1'b1;
    run_to_a(1700);
    fw_a = 32'h2000_0000;
    run_to_a(6210);
    check_drained();
    check_eq("pre_disable_bclk", bclk_a, 1);
    check_eq("pre_disable_locked", locked_a, 1);

    // Disable mid-frame with bclk high
    en_a = 1'b0;
    @(negedge clk);
    check_idle_a();

    // Re-enable at 2^30, then reset mid-frame with bclk and lrclk high
    fw_a = 32'h4000_0000;
    @(negedge clk);
    push_regime(0, 4, 0, 300);
    en_a = 1'b1;
    run_to_a(300);
    check_drained();
    check_eq("pre_reset_lrclk", lrclk_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_a();
    push_regime(0, 4, 0, 40);
    rst_n = 1'b1;
    run_to_a(40);
    check_drained();

    // Fractional word: 48 kHz frames from a 50 MHz refclk, over 40000 edges
    en_a = 1'b0;
    @(negedge clk);
    fw_a = 32'd527765581;
    @(negedge clk);
    mon_a_on = 1'b0;
    n_rise = 0;
    n_fall = 0;
    n_fs   = 0;
    en_a   = 1'b1;
    run_to_a(40000);
    ticks    = (64'd40000 * 64'd527765581) >> 32;
    exp_rise = longint'((ticks + 1) / 2);
    exp_fall = longint'(ticks / 2);
    exp_fs   = (exp_fall + FRAME_A - 1) / FRAME_A;
    check_eq("frac_rises", n_rise, exp_rise);
    check_eq("frac_falls", n_fall, exp_fall);
    check_eq("frac_frames", n_fs, exp_fs);
    check_eq("frac_locked", locked_a, 1);
    en_a = 1'b0;
    @(negedge clk);

    // DSP mode on B: one tick per cycle, 256-cycle frames, 2-cycle sync pulse.
    // The mode flip while running must be ignored.
    for (int t = 2; t <= 1030; t += 2) begin
      int p;
      p = t / 2 - 1;
      if (p % FRAME_B == 0) q_fs_b.push_back(t);
      if (p % FRAME_B == FRAME_B - 1 || (p % FRAME_B == 0 && p > 0)) q_lr_b.push_back(t);
    end
    en_b = 1'b1;
    @(negedge clk);
    mode_b = 1'b0;
    run_to_b(1030);
    check_eq("dsp_fs_left", q_fs_b.size(), 0);
    check_eq("dsp_lr_left", q_lr_b.size(), 0);
    check_eq("dsp_pulses", pulses_b, 4);
    check_eq("dsp_locked", locked_b, 1);
    en_b = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
